// File: rtl/dic_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares the clock's UART TX between echo, time and alarm streams.
// Optional stall-timeout abort is compiled in when DIC_TXARB_TIMEOUT_EN is defined.
module dic_tx_arbiter #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_echo,
    input  logic [DATA_W-1:0] echo_data,
    input  logic              echo_last,
    output logic              echo_ack,
    input  logic              req_time,
    input  logic [DATA_W-1:0] time_data,
    input  logic              time_last,
    output logic              time_ack,
    input  logic              req_alarm,
    input  logic [DATA_W-1:0] alarm_data,
    input  logic              alarm_last,
    output logic              alarm_ack,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              abort
);

    typedef enum logic {
        ST_IDLE,
        ST_XFER
    } state_t;

    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_ECHO  = 2'd1;
    localparam logic [1:0] OWN_TIME  = 2'd2;
    localparam logic [1:0] OWN_ALARM = 2'd3;

    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("dic_tx_arbiter: TIMEOUT_CYC must be at least 1");
    end

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        rr_last_q, rr_last_d;
    logic [1:0]        winner;
    logic              owner_req;
    logic              owner_last;
    logic [DATA_W-1:0] owner_data;
    logic              in_xfer;
    logic              xfer_fire;

`ifdef DIC_TXARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] stall_q, stall_d;
    logic             abort_q, abort_d;
`endif

    // Select the current owner's request, byte and last flag
    always_comb begin
        owner_req  = 1'b0;
        owner_last = 1'b0;
        owner_data = '0;
        case (grant_q)
            OWN_ECHO: begin
                owner_req  = req_echo;
                owner_last = echo_last;
                owner_data = echo_data;
            end
            OWN_TIME: begin
                owner_req  = req_time;
                owner_last = time_last;
                owner_data = time_data;
            end
            OWN_ALARM: begin
                owner_req  = req_alarm;
                owner_last = alarm_last;
                owner_data = alarm_data;
            end
            default: ;
        endcase
    end

    // Round-robin search starting just after the last packet owner
    always_comb begin
        winner = OWN_NONE;
        case (rr_last_q)
            OWN_ECHO: begin
                if (req_time)       winner = OWN_TIME;
                else if (req_alarm) winner = OWN_ALARM;
                else if (req_echo)  winner = OWN_ECHO;
            end
            OWN_TIME: begin
                if (req_alarm)      winner = OWN_ALARM;
                else if (req_echo)  winner = OWN_ECHO;
                else if (req_time)  winner = OWN_TIME;
            end
            default: begin
                if (req_echo)       winner = OWN_ECHO;
                else if (req_time)  winner = OWN_TIME;
                else if (req_alarm) winner = OWN_ALARM;
            end
        endcase
    end

    // Reset gates the datapath so no byte is handed over in the reset cycle
    assign in_xfer   = (state_q == ST_XFER) && !rst;
    assign tx_valid  = in_xfer && owner_req;
    assign tx_data   = in_xfer ? owner_data : '0;
    assign xfer_fire = tx_valid && tx_ready;
    assign echo_ack  = xfer_fire && (grant_q == OWN_ECHO);
    assign time_ack  = xfer_fire && (grant_q == OWN_TIME);
    assign alarm_ack = xfer_fire && (grant_q == OWN_ALARM);
    assign busy      = in_xfer;
    assign grant     = grant_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
`ifdef DIC_TXARB_TIMEOUT_EN
        stall_d   = stall_q;
        abort_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (winner != OWN_NONE) begin
                    state_d = ST_XFER;
                    grant_d = winner;
                end
            end
            ST_XFER: begin
                if (xfer_fire) begin
`ifdef DIC_TXARB_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (owner_last) begin
                        state_d   = ST_IDLE;
                        grant_d   = OWN_NONE;
                        rr_last_d = grant_q;
                    end
                end
`ifdef DIC_TXARB_TIMEOUT_EN
                else if (stall_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d   = ST_IDLE;
                    grant_d   = OWN_NONE;
                    rr_last_d = grant_q;
                    stall_d   = '0;
                    abort_d   = 1'b1;
                end else begin
                    stall_d = stall_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= OWN_NONE;
            rr_last_q <= OWN_ALARM;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
        end
    end

`ifdef DIC_TXARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            abort_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            abort_q <= abort_d;
        end
    end

    assign abort = abort_q;
`else
    assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_dic_tx_arbiter.sv
// Directed bench for dic_tx_arbiter: simple requester models feed packets, per-cycle outputs are checked
// against hand-written tables. The timeout scenario is selected by DIC_TXARB_TIMEOUT_EN (TIMEOUT_CYC=8).
module tb_dic_tx_arbiter;

    logic       clk;
    logic       rst;
    logic       req_echo, echo_last, echo_ack;
    logic [7:0] echo_data;
    logic       req_time, time_last, time_ack;
    logic [7:0] time_data;
    logic       req_alarm, alarm_last, alarm_ack;
    logic [7:0] alarm_data;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [1:0] grant;
    logic       busy, abort;

    int vectors;
    int miscompares;

    // Requester models: {last, data} per byte, advanced on each ack
    logic [8:0] e_pkt [8];
    logic [8:0] t_pkt [8];
    logic [8:0] a_pkt [8];
    int         e_len, t_len, a_len;
    int         e_idx, t_idx, a_idx;
    logic       e_en, t_en, a_en;

    logic [15:0] obs;
    assign obs = {grant, busy, tx_valid, tx_data, echo_ack, time_ack, alarm_ack, abort};

    dic_tx_arbiter #(
        .DATA_W      (8),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_echo   (req_echo),
        .echo_data  (echo_data),
        .echo_last  (echo_last),
        .echo_ack   (echo_ack),
        .req_time   (req_time),
        .time_data  (time_data),
        .time_last  (time_last),
        .time_ack   (time_ack),
        .req_alarm  (req_alarm),
        .alarm_data (alarm_data),
        .alarm_last (alarm_last),
        .alarm_ack  (alarm_ack),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .grant      (grant),
        .busy       (busy),
        .abort      (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ex(input logic [1:0] g, input logic v, input logic [7:0] d,
                                       input logic [2:0] ack, input logic ab = 1'b0);
        return {g, (g != 2'd0), v, d, ack, ab};
    endfunction

    task automatic drive_reqs();
        req_echo  = e_en && (e_idx < e_len);
        req_time  = t_en && (t_idx < t_len);
        req_alarm = a_en && (a_idx < a_len);
        {echo_last, echo_data}   = (e_idx < e_len) ? e_pkt[e_idx] : 9'h0;
        {time_last, time_data}   = (t_idx < t_len) ? t_pkt[t_idx] : 9'h0;
        {alarm_last, alarm_data} = (a_idx < a_len) ? a_pkt[a_idx] : 9'h0;
    endtask

    // Step one clock; requesters move to their next byte on an ack seen this cycle
    task automatic advance();
        logic ea, ta, aa;
        ea = echo_ack;
        ta = time_ack;
        aa = alarm_ack;
        @(posedge clk);
        #2;
        if (ea && e_idx < e_len) e_idx++;
        if (ta && t_idx < t_len) t_idx++;
        if (aa && a_idx < a_len) a_idx++;
        drive_reqs();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tx_ready = 1'b1;
        e_en = 1'b0; t_en = 1'b0; a_en = 1'b0;
        e_len = 0; t_len = 0; a_len = 0;
        e_idx = 0; t_idx = 0; a_idx = 0;
        for (int i = 0; i < 8; i++) begin
            e_pkt[i] = 9'h0; t_pkt[i] = 9'h0; a_pkt[i] = 9'h0;
        end
        drive_reqs();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic load_time_1234();
        t_pkt[0] = 9'h031; t_pkt[1] = 9'h032; t_pkt[2] = 9'h03A;
        t_pkt[3] = 9'h033; t_pkt[4] = 9'h134;
        t_len = 5;
        t_idx = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_ready = 1'b1;
        e_en = 1'b0; t_en = 1'b0; a_en = 1'b0;
        e_len = 0; t_len = 0; a_len = 0;
        e_idx = 0; t_idx = 0; a_idx = 0;
        drive_reqs();
        @(posedge clk);
        @(posedge clk);
        #3;
        vectors++;
        if (obs !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_hold: outputs got %h expected %h", obs, 16'h0000);
        end
        rst = 1'b0;
        @(posedge clk);
        #3;
        vectors++;
        if (obs !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_idle: outputs got %h expected %h", obs, 16'h0000);
        end
    endtask

    task automatic test_echo_single();
        logic [15:0] exp_t [4];
        apply_reset();
        e_pkt[0] = 9'h141; e_len = 1; e_en = 1'b1;
        drive_reqs();
        exp_t[0] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        exp_t[1] = ex(2'd1, 1'b1, 8'h41, 3'b100);
        exp_t[2] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        exp_t[3] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        for (int c = 0; c < 4; c++) begin
            #1;
            vectors++;
            if (obs !== exp_t[c]) begin
                miscompares++;
                $display("FAIL echo_single c%0d: outputs got %h expected %h", c, obs, exp_t[c]);
            end
            advance();
        end
    endtask

    task automatic test_all_three();
        logic [15:0] exp_t [7];
        apply_reset();
        e_pkt[0] = 9'h145; e_len = 1; e_en = 1'b1;
        t_pkt[0] = 9'h154; t_len = 1; t_en = 1'b1;
        a_pkt[0] = 9'h141; a_len = 1; a_en = 1'b1;
        drive_reqs();
        exp_t[0] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        exp_t[1] = ex(2'd1, 1'b1, 8'h45, 3'b100);
        exp_t[2] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        exp_t[3] = ex(2'd2, 1'b1, 8'h54, 3'b010);
        exp_t[4] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        exp_t[5] = ex(2'd3, 1'b1, 8'h41, 3'b001);
        exp_t[6] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        for (int c = 0; c < 7; c++) begin
            #1;
            vectors++;
            if (obs !== exp_t[c]) begin
                miscompares++;
                $display("FAIL all_three c%0d: outputs got %h expected %h", c, obs, exp_t[c]);
            end
            advance();
        end
    endtask

    task automatic test_grant_lock();
        logic [15:0] exp_t [9];
        apply_reset();
        load_time_1234();
        t_en = 1'b1;
        e_pkt[0] = 9'h165; e_len = 1;
        drive_reqs();
        exp_t[0] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        exp_t[1] = ex(2'd2, 1'b1, 8'h31, 3'b010);
        exp_t[2] = ex(2'd2, 1'b1, 8'h32, 3'b010);
        exp_t[3] = ex(2'd2, 1'b1, 8'h3A, 3'b010);
        exp_t[4] = ex(2'd2, 1'b1, 8'h33, 3'b010);
        exp_t[5] = ex(2'd2, 1'b1, 8'h34, 3'b010);
        exp_t[6] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        exp_t[7] = ex(2'd1, 1'b1, 8'h65, 3'b100);
        exp_t[8] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        for (int c = 0; c < 9; c++) begin
            if (c == 3) begin
                e_en = 1'b1;
                drive_reqs();
            end
            #1;
            vectors++;
            if (obs !== exp_t[c]) begin
                miscompares++;
                $display("FAIL grant_lock c%0d: outputs got %h expected %h", c, obs, exp_t[c]);
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_t [10];
        logic        rdy_t [10];
        apply_reset();
        load_time_1234();
        t_en = 1'b1;
        drive_reqs();
        exp_t[0] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        exp_t[1] = ex(2'd2, 1'b1, 8'h31, 3'b010);
        exp_t[2] = ex(2'd2, 1'b1, 8'h32, 3'b000);
        exp_t[3] = ex(2'd2, 1'b1, 8'h32, 3'b000);
        exp_t[4] = ex(2'd2, 1'b1, 8'h32, 3'b000);
        exp_t[5] = ex(2'd2, 1'b1, 8'h32, 3'b010);
        exp_t[6] = ex(2'd2, 1'b1, 8'h3A, 3'b010);
        exp_t[7] = ex(2'd2, 1'b1, 8'h33, 3'b010);
        exp_t[8] = ex(2'd2, 1'b1, 8'h34, 3'b010);
        exp_t[9] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        for (int c = 0; c < 10; c++) rdy_t[c] = !(c >= 2 && c <= 4);
        for (int c = 0; c < 10; c++) begin
            tx_ready = rdy_t[c];
            #1;
            vectors++;
            if (obs !== exp_t[c]) begin
                miscompares++;
                $display("FAIL backpressure c%0d: outputs got %h expected %h", c, obs, exp_t[c]);
            end
            advance();
        end
        tx_ready = 1'b1;
    endtask

    task automatic test_reset_mid_packet();
        logic [15:0] exp_t [11];
        apply_reset();
        load_time_1234();
        t_en = 1'b1;
        drive_reqs();
        exp_t[0]  = ex(2'd0, 1'b0, 8'h00, 3'b000);
        exp_t[1]  = ex(2'd2, 1'b1, 8'h31, 3'b010);
        exp_t[2]  = ex(2'd2, 1'b1, 8'h32, 3'b010);
        exp_t[3]  = 16'h0000;
        exp_t[4]  = ex(2'd0, 1'b0, 8'h00, 3'b000);
        exp_t[5]  = ex(2'd2, 1'b1, 8'h31, 3'b010);
        exp_t[6]  = ex(2'd2, 1'b1, 8'h32, 3'b010);
        exp_t[7]  = ex(2'd2, 1'b1, 8'h3A, 3'b010);
        exp_t[8]  = ex(2'd2, 1'b1, 8'h33, 3'b010);
        exp_t[9]  = ex(2'd2, 1'b1, 8'h34, 3'b010);
        exp_t[10] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        for (int c = 0; c < 11; c++) begin
            if (c == 3) begin
                rst = 1'b1;
                t_idx = 0;
                drive_reqs();
            end
            if (c == 4) rst = 1'b0;
            #1;
            vectors++;
            if (c == 3) begin
                if ({tx_valid, time_ack} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL reset_mid c3: tx_valid,time_ack got %b expected 00", {tx_valid, time_ack});
                end
            end else if (obs !== exp_t[c]) begin
                miscompares++;
                $display("FAIL reset_mid c%0d: outputs got %h expected %h", c, obs, exp_t[c]);
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_t [7];
        // same requester, two single-byte packets
        apply_reset();
        e_pkt[0] = 9'h161; e_pkt[1] = 9'h162; e_len = 2; e_en = 1'b1;
        drive_reqs();
        exp_t[0] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        exp_t[1] = ex(2'd1, 1'b1, 8'h61, 3'b100);
        exp_t[2] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        exp_t[3] = ex(2'd1, 1'b1, 8'h62, 3'b100);
        exp_t[4] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++;
            if (obs !== exp_t[c]) begin
                miscompares++;
                $display("FAIL b2b_same c%0d: outputs got %h expected %h", c, obs, exp_t[c]);
            end
            advance();
        end
        // time is pending, so it must slot in between the two echo packets
        apply_reset();
        e_pkt[0] = 9'h161; e_pkt[1] = 9'h162; e_len = 2; e_en = 1'b1;
        t_pkt[0] = 9'h174; t_len = 1; t_en = 1'b1;
        drive_reqs();
        exp_t[0] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        exp_t[1] = ex(2'd1, 1'b1, 8'h61, 3'b100);
        exp_t[2] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        exp_t[3] = ex(2'd2, 1'b1, 8'h74, 3'b010);
        exp_t[4] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        exp_t[5] = ex(2'd1, 1'b1, 8'h62, 3'b100);
        exp_t[6] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        for (int c = 0; c < 7; c++) begin
            #1;
            vectors++;
            if (obs !== exp_t[c]) begin
                miscompares++;
                $display("FAIL b2b_rr c%0d: outputs got %h expected %h", c, obs, exp_t[c]);
            end
            advance();
        end
    endtask

`ifdef DIC_TXARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [15:0] exp_t [14];
        apply_reset();
        load_time_1234();
        t_en = 1'b1;
        a_pkt[0] = 9'h121; a_len = 1;
        drive_reqs();
        for (int c = 0; c < 14; c++) exp_t[c] = 16'h0000;
        exp_t[0]  = ex(2'd0, 1'b0, 8'h00, 3'b000);
        exp_t[1]  = ex(2'd2, 1'b1, 8'h31, 3'b010);
        exp_t[2]  = ex(2'd2, 1'b1, 8'h32, 3'b010);
        exp_t[11] = ex(2'd0, 1'b0, 8'h00, 3'b000, 1'b1);
        exp_t[12] = ex(2'd3, 1'b1, 8'h21, 3'b001);
        exp_t[13] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        for (int c = 0; c < 14; c++) begin
            if (c == 3) begin
                t_en = 1'b0;
                a_en = 1'b1;
                drive_reqs();
            end
            #1;
            vectors++;
            if (c >= 3 && c <= 10) begin
                if ({grant, busy, tx_valid, echo_ack, time_ack, alarm_ack, abort} !==
                    {2'd2, 1'b1, 1'b0, 3'b000, 1'b0}) begin
                    miscompares++;
                    $display("FAIL timeout_stall c%0d: grant,busy,valid,acks,abort got %b expected 10100000",
                             c, {grant, busy, tx_valid, echo_ack, time_ack, alarm_ack, abort});
                end
            end else if (obs !== exp_t[c]) begin
                miscompares++;
                $display("FAIL timeout c%0d: outputs got %h expected %h", c, obs, exp_t[c]);
            end
            advance();
        end
    endtask
`else
    task automatic test_owner_stall();
        logic [15:0] exp_t [19];
        apply_reset();
        t_pkt[0] = 9'h031; t_pkt[1] = 9'h032; t_pkt[2] = 9'h133; t_len = 3; t_en = 1'b1;
        e_pkt[0] = 9'h165; e_len = 1;
        drive_reqs();
        for (int c = 0; c < 19; c++) exp_t[c] = 16'h0000;
        exp_t[0]  = ex(2'd0, 1'b0, 8'h00, 3'b000);
        exp_t[1]  = ex(2'd2, 1'b1, 8'h31, 3'b010);
        exp_t[14] = ex(2'd2, 1'b1, 8'h32, 3'b010);
        exp_t[15] = ex(2'd2, 1'b1, 8'h33, 3'b010);
        exp_t[16] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        exp_t[17] = ex(2'd1, 1'b1, 8'h65, 3'b100);
        exp_t[18] = ex(2'd0, 1'b0, 8'h00, 3'b000);
        for (int c = 0; c < 19; c++) begin
            if (c == 2) begin
                t_en = 1'b0;
                e_en = 1'b1;
                drive_reqs();
            end
            if (c == 14) begin
                t_en = 1'b1;
                drive_reqs();
            end
            #1;
            vectors++;
            if (c >= 2 && c <= 13) begin
                if ({grant, busy, tx_valid, echo_ack, time_ack, alarm_ack, abort} !==
                    {2'd2, 1'b1, 1'b0, 3'b000, 1'b0}) begin
                    miscompares++;
                    $display("FAIL owner_stall c%0d: grant,busy,valid,acks,abort got %b expected 10100000",
                             c, {grant, busy, tx_valid, echo_ack, time_ack, alarm_ack, abort});
                end
            end else if (obs !== exp_t[c]) begin
                miscompares++;
                $display("FAIL owner_stall c%0d: outputs got %h expected %h", c, obs, exp_t[c]);
            end
            advance();
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_echo_single();
        test_all_three();
        test_grant_lock();
        test_backpressure();
        test_reset_mid_packet();
        test_back_to_back();
`ifdef DIC_TXARB_TIMEOUT_EN
        test_timeout();
`else
        test_owner_stall();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
